// File: rtl/m_axi_lite_traffic_if.sv
// AXI4-Lite bus bundle for the traffic generator: five channels, with a master
// modport and a slave modport.
interface m_axi_lite_traffic_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
);
    logic                  awvalid;
    logic [AWIDTH-1:0]     awaddr;
    logic [2:0]            awprot;
    logic                  awready;
    logic                  wvalid;
    logic [DWIDTH-1:0]     wdata;
    logic [DWIDTH/8-1:0]   wstrb;
    logic                  wready;
    logic                  bvalid;
    logic [1:0]            bresp;
    logic                  bready;
    logic                  arvalid;
    logic [AWIDTH-1:0]     araddr;
    logic [2:0]            arprot;
    logic                  arready;
    logic                  rvalid;
    logic [DWIDTH-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  rready;

    modport master (
        output awvalid, awaddr, awprot, input awready,
        output wvalid, wdata, wstrb, input wready,
        input bvalid, bresp, output bready,
        output arvalid, araddr, arprot, input arready,
        input rvalid, rdata, rresp, output rready
    );

    modport slave (
        input awvalid, awaddr, awprot, output awready,
        input wvalid, wdata, wstrb, output wready,
        output bvalid, bresp, input bready,
        input arvalid, araddr, arprot, output arready,
        output rvalid, rdata, rresp, input rready
    );
endinterface

// File: rtl/m_axi_lite_traffic.sv
// AXI4-Lite master traffic generator and checker. It writes and/or reads back
// a seed-derived incrementing pattern and counts response and data errors.
module m_axi_lite_traffic #(
    parameter int                DWIDTH    = 32,
    parameter int                AWIDTH    = 32,
    parameter int                TXN_NUM   = 4,
    parameter logic [AWIDTH-1:0] BASE_ADDR = '0,
    parameter int                ADDR_STEP = DWIDTH / 8,
    parameter int                ECNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 xrst,
    input  logic                 req,
    input  logic [1:0]           mode,
    input  logic [DWIDTH-1:0]    seed,
    output logic                 busy,
    output logic                 ack,
    output logic                 err,
    output logic [ECNT_W-1:0]    err_cnt,
    output logic [DWIDTH-1:0]    probe,
    m_axi_lite_traffic_if.master axi
);
    localparam int IDX_W = (TXN_NUM > 1) ? $clog2(TXN_NUM) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_COMP  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        mode_q;
    logic [DWIDTH-1:0] seed_q;
    logic [DWIDTH-1:0] rd_exp;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic              wr_last, rd_last, verify;
    logic [1:0]        err_inc;

    function automatic logic [ECNT_W-1:0] sat_add(input logic [ECNT_W-1:0] a,
                                                  input logic [1:0] b);
        logic [ECNT_W:0] s;
        s = {1'b0, a} + (ECNT_W + 1)'(b);
        return s[ECNT_W] ? {ECNT_W{1'b1}} : s[ECNT_W-1:0];
    endfunction

    assign axi.awprot = 3'b000;
    assign axi.arprot = 3'b001;
    assign axi.wstrb  = '1;
    assign probe      = {{(DWIDTH - 2){1'b0}}, state};

    assign aw_hs   = axi.awvalid & axi.awready;
    assign w_hs    = axi.wvalid & axi.wready;
    assign b_hs    = axi.bvalid & axi.bready;
    assign ar_hs   = axi.arvalid & axi.arready;
    assign r_hs    = axi.rvalid & axi.rready;
    assign wr_last = (wr_idx == IDX_W'(TXN_NUM - 1));
    assign rd_last = (rd_idx == IDX_W'(TXN_NUM - 1));
    assign verify  = (mode_q != 2'b01);

    // A read beat can carry both a bad response and bad data, so up to two errors per cycle.
    always_comb begin
        err_inc = 2'd0;
        if (b_hs && axi.bresp[1]) err_inc = err_inc + 2'd1;
        if (r_hs && axi.rresp[1]) err_inc = err_inc + 2'd1;
        if (r_hs && verify && (axi.rdata != rd_exp)) err_inc = err_inc + 2'd1;
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            ack         <= 1'b0;
            err         <= 1'b0;
            err_cnt     <= '0;
            mode_q      <= 2'b00;
            seed_q      <= '0;
            rd_exp      <= '0;
            wr_idx      <= '0;
            rd_idx      <= '0;
            axi.awvalid <= 1'b0;
            axi.wvalid  <= 1'b0;
            axi.bready  <= 1'b0;
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b0;
            axi.awaddr  <= BASE_ADDR;
            axi.araddr  <= BASE_ADDR;
            axi.wdata   <= '0;
        end else begin
            if (err_inc != 2'd0) begin
                err     <= 1'b1;
                err_cnt <= sat_add(err_cnt, err_inc);
            end
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        mode_q     <= mode;
                        seed_q     <= seed;
                        wr_idx     <= '0;
                        rd_idx     <= '0;
                        ack        <= 1'b0;
                        err        <= 1'b0;
                        err_cnt    <= '0;
                        busy       <= 1'b1;
                        axi.awaddr <= BASE_ADDR;
                        axi.araddr <= BASE_ADDR;
                        axi.wdata  <= seed;
                        rd_exp     <= seed;
                        if (mode == 2'b10) begin
                            state       <= ST_READ;
                            axi.arvalid <= 1'b1;
                        end else begin
                            state       <= ST_WRITE;
                            axi.awvalid <= 1'b1;
                            axi.wvalid  <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (aw_hs) axi.awvalid <= 1'b0;
                    if (w_hs)  axi.wvalid  <= 1'b0;
                    // Open the B channel only once both AW and W have been accepted.
                    if ((axi.awvalid || axi.wvalid) && (!axi.awvalid || aw_hs) &&
                        (!axi.wvalid || w_hs))
                        axi.bready <= 1'b1;
                    if (b_hs) begin
                        axi.bready <= 1'b0;
                        if (wr_last) begin
                            if (mode_q == 2'b01) begin
                                state <= ST_COMP;
                            end else begin
                                state       <= ST_READ;
                                axi.arvalid <= 1'b1;
                                axi.araddr  <= BASE_ADDR;
                                rd_exp      <= seed_q;
                            end
                        end else begin
                            wr_idx      <= wr_idx + IDX_W'(1);
                            axi.awaddr  <= axi.awaddr + AWIDTH'(ADDR_STEP);
                            axi.wdata   <= axi.wdata + DWIDTH'(1);
                            axi.awvalid <= 1'b1;
                            axi.wvalid  <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (ar_hs) begin
                        axi.arvalid <= 1'b0;
                        axi.rready  <= 1'b1;
                    end
                    if (r_hs) begin
                        axi.rready <= 1'b0;
                        if (rd_last) begin
                            state <= ST_COMP;
                        end else begin
                            rd_idx      <= rd_idx + IDX_W'(1);
                            axi.araddr  <= axi.araddr + AWIDTH'(ADDR_STEP);
                            rd_exp      <= rd_exp + DWIDTH'(1);
                            axi.arvalid <= 1'b1;
                        end
                    end
                end
                ST_COMP: begin
                    ack   <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_m_axi_lite_traffic.sv
// Bench for m_axi_lite_traffic: memory slave model with configurable ready
// stalls, queue scoreboard for AW/W/AR beats and run completion.
module tb_m_axi_lite_traffic;
    localparam int DW = 32;
    localparam int AW = 32;

    typedef struct {
        logic        e;
        logic [15:0] c;
        int          cycles;
    } done_t;

    logic clk = 1'b0;
    logic xrst = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int req_cyc = 0;

    logic          req = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [DW-1:0] seed = '0;
    logic          busy, ack, err;
    logic [15:0]   err_cnt;
    logic [DW-1:0] probe;

    m_axi_lite_traffic_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    m_axi_lite_traffic #(
        .DWIDTH(DW), .AWIDTH(AW), .TXN_NUM(4), .BASE_ADDR(32'h0),
        .ADDR_STEP(4), .ECNT_W(16)
    ) dut (
        .clk(clk), .xrst(xrst), .req(req), .mode(mode), .seed(seed),
        .busy(busy), .ack(ack), .err(err), .err_cnt(err_cnt), .probe(probe),
        .axi(bus)
    );

    // Second instance with a narrow error counter so saturation is reachable in one run.
    logic          sreq = 1'b0;
    logic          sbusy, sack, serr;
    logic [2:0]    scnt;
    logic [DW-1:0] sprobe;
    logic          srvalid;

    m_axi_lite_traffic_if #(.DWIDTH(DW), .AWIDTH(AW)) sbus ();

    m_axi_lite_traffic #(
        .DWIDTH(DW), .AWIDTH(AW), .TXN_NUM(4), .BASE_ADDR(32'h0),
        .ADDR_STEP(4), .ECNT_W(3)
    ) u_sat (
        .clk(clk), .xrst(xrst), .req(sreq), .mode(2'b10), .seed(32'h0),
        .busy(sbusy), .ack(sack), .err(serr), .err_cnt(scnt), .probe(sprobe),
        .axi(sbus)
    );

    assign sbus.awready = 1'b1;
    assign sbus.wready  = 1'b1;
    assign sbus.bvalid  = 1'b0;
    assign sbus.bresp   = 2'b00;
    assign sbus.arready = 1'b1;
    assign sbus.rvalid  = srvalid;
    assign sbus.rdata   = 32'hDEAD_BEEF;
    assign sbus.rresp   = 2'b10;

    always @(posedge clk) begin
        if (!xrst) srvalid <= 1'b0;
        else if (sbus.arvalid) srvalid <= 1'b1;
        else if (sbus.rready && srvalid) srvalid <= 1'b0;
    end

    // Memory slave model for the main instance
    int          aw_dly = 0, w_dly = 0, bresp_err_idx = -1;
    int          aw_cnt = 0, w_cnt = 0, b_num = 0;
    logic        aw_got = 1'b0, w_got = 1'b0;
    logic [31:0] aw_a = '0, w_d = '0;
    logic [31:0] mem [16];
    logic        ld_en = 1'b0;
    logic [3:0]  ld_a = '0;
    logic [31:0] ld_d = '0;
    logic        s_aw_hs, s_w_hs, s_ar_hs, aw_now, w_now;
    logic [31:0] aw_sel, w_sel;

    assign bus.awready = (aw_cnt >= aw_dly);
    assign bus.wready  = (w_cnt >= w_dly);
    assign bus.arready = 1'b1;
    assign s_aw_hs = bus.awvalid & bus.awready;
    assign s_w_hs  = bus.wvalid & bus.wready;
    assign s_ar_hs = bus.arvalid & bus.arready;
    assign aw_now  = aw_got | s_aw_hs;
    assign w_now   = w_got | s_w_hs;
    assign aw_sel  = aw_got ? aw_a : bus.awaddr;
    assign w_sel   = w_got ? w_d : bus.wdata;

    always @(posedge clk) begin
        if (!xrst) begin
            aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0; b_num <= 0;
            bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
            bus.rvalid <= 1'b0; bus.rresp <= 2'b00; bus.rdata <= '0;
        end else begin
            if (ld_en) mem[ld_a] <= ld_d;
            if (bus.awvalid && !bus.awready) aw_cnt <= aw_cnt + 1;
            else if (s_aw_hs) aw_cnt <= 0;
            if (bus.wvalid && !bus.wready) w_cnt <= w_cnt + 1;
            else if (s_w_hs) w_cnt <= 0;
            if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
            if (aw_now && w_now) begin
                mem[aw_sel[5:2]] <= w_sel;
                bus.bvalid <= 1'b1;
                bus.bresp  <= (b_num == bresp_err_idx) ? 2'b10 : 2'b00;
                b_num      <= b_num + 1;
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
            end else begin
                if (s_aw_hs) begin aw_got <= 1'b1; aw_a <= bus.awaddr; end
                if (s_w_hs)  begin w_got  <= 1'b1; w_d  <= bus.wdata;  end
            end
            if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
            if (s_ar_hs) begin
                bus.rvalid <= 1'b1;
                bus.rdata  <= mem[bus.araddr[5:2]];
                bus.rresp  <= 2'b00;
            end
            if (!busy) b_num <= 0;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name, input logic [63:0] act);
        total++;
        bad++;
        $display("FAIL %s: got 0x%0h want none", name, act);
    endtask

    // Scoreboard monitor
    logic [31:0] exp_aw [$];
    logic [31:0] exp_w [$];
    logic [31:0] exp_ar [$];
    done_t       exp_done [$];
    done_t       mon_d;
    logic        ack_d = 1'b0;

    always @(negedge clk) begin
        ack_d <= ack;
        if (xrst) begin
            if (bus.awvalid && bus.awready) begin
                if (exp_aw.size() == 0) note_fail("awaddr unexpected", bus.awaddr);
                else check("awaddr", bus.awaddr, exp_aw.pop_front());
            end
            if (bus.wvalid && bus.wready) begin
                if (exp_w.size() == 0) note_fail("wdata unexpected", bus.wdata);
                else check("wdata", bus.wdata, exp_w.pop_front());
            end
            if (bus.arvalid && bus.arready) begin
                if (exp_ar.size() == 0) note_fail("araddr unexpected", bus.araddr);
                else check("araddr", bus.araddr, exp_ar.pop_front());
            end
            if (ack && !ack_d) begin
                if (exp_done.size() == 0) note_fail("ack unexpected", ack);
                else begin
                    mon_d = exp_done.pop_front();
                    check("done_err", err, mon_d.e);
                    check("done_err_cnt", err_cnt, mon_d.c);
                    check("done_cycles", cyc - req_cyc, mon_d.cycles);
                end
            end
        end
    end

    task automatic push_run(input logic [1:0] m, input logic [31:0] s, input int nrd,
                            input logic e, input logic [15:0] c, input int cycles);
        for (int i = 0; i < 4; i++) begin
            if (m != 2'b10) begin
                exp_aw.push_back(32'(i * 4));
                exp_w.push_back(s + 32'(i));
            end
        end
        for (int i = 0; i < nrd; i++) exp_ar.push_back(32'(i * 4));
        if (cycles > 0) exp_done.push_back('{e, c, cycles});
    endtask

    task automatic start(input logic [1:0] m, input logic [31:0] s);
        req = 1'b1; mode = m; seed = s;
        @(posedge clk); #1;
        req_cyc = cyc;
        req = 1'b0;
    endtask

    task automatic wait_ack(input int limit, input string name);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!ack && n < limit);
        if (!ack) note_fail({name, " ack timeout"}, 64'(n));
    endtask

    task automatic preload(input logic [3:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_a = a; ld_d = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, wfirst, early;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_probe", probe, 0);
        check("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid}, 0);
        check("rst_readys", {bus.bready, bus.rready}, 0);
        check("rst_awaddr", bus.awaddr, 0);
        check("rst_wdata", bus.wdata, 0);
        check("rst_wstrb", bus.wstrb, 4'hF);
        check("rst_prot", {bus.awprot, bus.arprot}, 6'b000_001);
        xrst = 1'b1;
        @(negedge clk);

        // Zero-wait write then read-back
        push_run(2'b00, 32'h10, 4, 1'b0, 16'd0, 17);
        start(2'b00, 32'h10);
        wait_ack(100, "mode00");

        // Stalled AW (3 cycles) and W (1 cycle) per beat
        aw_dly = 3; w_dly = 1;
        push_run(2'b00, 32'h20, 4, 1'b0, 16'd0, 29);
        start(2'b00, 32'h20);
        n = 0; wfirst = 0; early = 0;
        do begin
            @(negedge clk); n++;
            if (bus.awvalid && !bus.wvalid) wfirst++;
            if (bus.bready && (bus.awvalid || bus.wvalid)) early++;
        end while (!ack && n < 200);
        if (!ack) note_fail("stall ack timeout", 64'(n));
        check("stall_w_drops_first", wfirst != 0, 1);
        check("stall_bready_early", early, 0);
        aw_dly = 0; w_dly = 0;

        // Read-only against a slave holding one bad word
        preload(4'd0, 32'h10); preload(4'd1, 32'h11);
        preload(4'd2, 32'hFF); preload(4'd3, 32'h13);
        push_run(2'b10, 32'h10, 4, 1'b1, 16'd1, 9);
        start(2'b10, 32'h10);
        wait_ack(100, "mode10");

        // Back-to-back write-only run with SLVERR on txn 2
        bresp_err_idx = 2;
        push_run(2'b01, 32'h40, 0, 1'b1, 16'd1, 9);
        start(2'b01, 32'h40);
        wait_ack(100, "mode01");
        bresp_err_idx = -1;
        @(negedge clk);

        // Wrapping seed, ignored mid-run req, reset during the third read
        push_run(2'b11, 32'hFFFF_FFFF, 3, 1'b0, 16'd0, 0);
        start(2'b11, 32'hFFFF_FFFF);
        @(negedge clk);
        req = 1'b1; mode = 2'b01; seed = 32'h5;
        @(negedge clk);
        req = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!(bus.arvalid && bus.araddr == 32'h8) && n < 100);
        if (n >= 100) note_fail("third read timeout", 64'(n));
        @(negedge clk);
        check("rd3_rready", bus.rready, 1);
        check("rd3_err", err, 0);
        check("rd3_busy", busy, 1);
        xrst = 1'b0;
        #1;
        check("xrst_valids", {bus.awvalid, bus.wvalid, bus.arvalid}, 0);
        check("xrst_readys", {bus.bready, bus.rready}, 0);
        check("xrst_probe", probe, 0);
        check("xrst_ack_busy", {ack, busy}, 0);
        check("xrst_araddr", bus.araddr, 0);
        repeat (2) @(negedge clk);
        xrst = 1'b1;
        @(negedge clk);
        check("left_aw", exp_aw.size(), 0);
        check("left_w", exp_w.size(), 0);
        check("left_ar", exp_ar.size(), 0);
        check("left_done", exp_done.size(), 0);

        // Error counter saturation on the narrow instance
        sreq = 1'b1;
        @(posedge clk); #1;
        sreq = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!sack && n < 100);
        check("sat_ack", sack, 1);
        check("sat_err", serr, 1);
        check("sat_err_cnt", scnt, 3'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
